down_counter: RTL and testbench
===============================

# down_counter

Loadable, enable-gated down counter with terminal-count detection and a small control FSM. It is the count-down counterpart of the team's free-running up counter: software or an upstream block loads a start value, and the block counts it down to zero. It reports completion with a one-cycle terminal-count pulse and a sticky done flag. It sits beside the up counter in timer and delay-generation paths.

## Interface
- WIDTH, 6, counter and load-value width in bits (legal range 2..32)
- clk  input  1  rising-edge clock; all state changes on posedge clk
- rst  input  1  synchronous, active-high reset; highest priority
- load  input  1  single-cycle request; captures load_val
- load_val  input  WIDTH  start value sampled when load=1
- en  input  1  count enable; decrement only when high in RUN
- abort  input  1  cancels the current count and returns to IDLE
- count  output  WIDTH  current count value (registered)
- busy  output  1  high while in RUN
- done  output  1  high while in DONE (sticky until load, abort or rst)
- tc  output  1  one-cycle terminal-count pulse (registered)

## Operation
- States: IDLE, RUN, DONE. Encoding is free. busy=(state==RUN) and done=(state==DONE).
- Priority per cycle: rst > abort > load > en-decrement > hold.
- Reset: state=IDLE, count=0, tc=0, busy=0, done=0, reload register=0.
- IDLE: count holds 0, en is ignored, tc=0.
- Load is accepted in any state:
  - count<=load_val and reload<=load_val.
  - If load_val!=0: state<=RUN.
  - If load_val==0: state<=DONE and tc pulses for one cycle.
  - A load in RUN restarts the count; no tc is generated for the interrupted run.
- RUN, en=1, count>1: count<=count-1.
- RUN, en=1, count==1: count<=0, tc<=1 for one cycle, state<=DONE.
- RUN, en=0: count and state hold; tc=0.
- DONE: count holds 0. done stays high until load, abort or rst. en is ignored.
- Abort in RUN or DONE: state<=IDLE and count<=0, with no tc. Abort in IDLE has no effect.
- Arithmetic is unsigned. Count never wraps below 0 because the decrement only occurs when count>=1.
- tc is registered and low in every cycle not listed above.

## Timing
- Load at edge N: count=load_val and busy=1 visible after edge N.
- With en held high from edge N+1: count reaches 0 after edge N+load_val. tc and done are high in that same cycle.
- Load-to-tc latency is load_val cycles plus the number of en=0 cycles in RUN.
- tc width is exactly 1 cycle.
- done rises in the same cycle as tc. busy falls in the same cycle.
- All outputs are registered, with no combinational input-to-output path.
- Reset mid-count takes effect at the next edge. The interrupted run produces no tc.

## Configuration
- DOWN_COUNTER_AUTORELOAD_EN defined:
  - In RUN, en=1 and count==1: count<=reload, tc pulses, and state stays RUN. done never asserts from a reload event.
  - reload==1 therefore gives tc in every enabled cycle.
  - Load with load_val==0 still goes to DONE.
- Not defined: single-shot behaviour as described in Operation. The reload register may be optimised away.

## Test plan
- Reset then idle: rst high 2 cycles, then en=1 for 5 cycles -> count=0, busy=0, done=0, tc=0 throughout.
- Basic countdown, WIDTH=6: load load_val=5, en=1 -> count 5,4,3,2,1,0 on successive cycles. tc high exactly once, with count=0. done high and count=0 held for the following 10 cycles.
- Enable gating and overflow edge: load 63, toggle en every cycle -> count decrements only on en=1 cycles. It reaches 0 after 63 enabled cycles, with no wrap to 63 after 0.
- Priority and restart:
  - Load 10, then after 3 decrements load 4 -> count=4, no tc, and tc occurs 4 enabled cycles later.
  - Load and abort in the same cycle -> IDLE, count=0.
  - rst with load in the same cycle -> reset values.
- Zero load and mid-run abort:
  - load_val=0 -> done=1 and a single tc on the next cycle.
  - Load 20, abort after 5 cycles -> IDLE, count=0, no tc.
  - rst at count=7 -> all outputs at reset values next cycle.
- Autoreload (macro defined): load 3, en=1 for 12 cycles -> count 3,2,1,0→3 is replaced by the sequence 3,2,1,3,2,1,… with tc on every reload cycle (4 pulses) and done=0 throughout.

Source files
------------

// File: rtl/down_counter_if.sv
// down_counter_if: load/enable/abort controls and count/status outputs of down_counter
interface down_counter_if #(parameter int WIDTH = 6);
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             en;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             done;
   logic             tc;
   modport master (output load, load_val, en, abort, input count, busy, done, tc);
   modport slave (input load, load_val, en, abort, output count, busy, done, tc);
endinterface

// File: rtl/down_counter.sv
// down_counter: loadable enable-gated down counter with one-cycle tc pulse and sticky done.
// Define DOWN_COUNTER_AUTORELOAD_EN to reload the last loaded value on terminal count instead of stopping.
module down_counter #(parameter int WIDTH = 6) (
   input logic          clk,
   input logic          rst,
   down_counter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic             tc;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         tc    <= 1'b0;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
         reload <= '0;
`endif
      end else begin
         tc <= 1'b0;
         // abort outranks load even in IDLE, so a simultaneous load is discarded
         if (bus.abort) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (bus.load) begin
            cnt   <= bus.load_val;
            state <= (bus.load_val == '0) ? DONE : RUN;
            tc    <= (bus.load_val == '0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            reload <= bus.load_val;
`endif
         end else if (state == RUN && bus.en) begin
            if (cnt == WIDTH'(1)) begin
               tc <= 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
               cnt <= reload;
`else
               cnt   <= '0;
               state <= DONE;
`endif
            end else begin
               cnt <= cnt - WIDTH'(1);
            end
         end
      end
   end
   assign bus.count = cnt;
   assign bus.busy  = (state == RUN);
   assign bus.done  = (state == DONE);
   assign bus.tc    = tc;
endmodule

// File: tb/tb_down_counter.sv
// tb_down_counter: directed self-checking bench for down_counter
module tb_down_counter;
   localparam int W = 6;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
   localparam bit AR = 1'b1;
`else
   localparam bit AR = 1'b0;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   down_counter_if #(.WIDTH(W)) bus ();
   down_counter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [W-1:0] c, input logic b, input logic d, input logic t);
      chk(tag, 32'({bus.count, bus.busy, bus.done, bus.tc}), 32'({c, b, d, t}));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic l, input logic [W-1:0] lv, input logic e, input logic a);
      bus.load = l;
      bus.load_val = lv;
      bus.en = e;
      bus.abort = a;
   endtask

   initial begin
      logic [W-1:0] e;
      logic         t;
      int           pulses;
      drive(1'b0, '0, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      tick();
      chk_out("reset", '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      bus.en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_out("idle_en", '0, 1'b0, 1'b0, 1'b0);
      end
`ifndef DOWN_COUNTER_AUTORELOAD_EN
      drive(1'b1, W'(5), 1'b1, 1'b0);
      tick();
      chk_out("basic_load", W'(5), 1'b1, 1'b0, 1'b0);
      bus.load = 1'b0;
      for (int i = 4; i >= 1; i--) begin
         tick();
         chk_out("basic_dec", W'(i), 1'b1, 1'b0, 1'b0);
      end
      tick();
      chk_out("basic_tc", '0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_out("basic_hold", '0, 1'b0, 1'b1, 1'b0);
      end
      drive(1'b1, W'(63), 1'b0, 1'b0);
      tick();
      chk_out("gate_load", W'(63), 1'b1, 1'b0, 1'b0);
      bus.load = 1'b0;
      e = W'(63);
      for (int i = 0; i < 132; i++) begin
         bus.en = (i % 2 == 0) || (i >= 126);
         t = bus.en && (e == W'(1));
         if (bus.en && e != '0) e = e - W'(1);
         tick();
         chk_out("gate", e, e != '0, e == '0, t);
      end
`endif
      drive(1'b1, W'(10), 1'b1, 1'b0);
      tick();
      bus.load = 1'b0;
      for (int i = 9; i >= 7; i--) begin
         tick();
         chk_out("restart_dec", W'(i), 1'b1, 1'b0, 1'b0);
      end
      bus.load = 1'b1;
      bus.load_val = W'(4);
      tick();
      chk_out("restart_load", W'(4), 1'b1, 1'b0, 1'b0);
      bus.load = 1'b0;
      for (int i = 3; i >= 1; i--) begin
         tick();
         chk_out("restart_dec2", W'(i), 1'b1, 1'b0, 1'b0);
      end
      tick();
      chk_out("restart_tc", AR ? W'(4) : W'(0), AR, !AR, 1'b1);
      drive(1'b1, W'(9), 1'b1, 1'b1);
      tick();
      chk_out("load_abort", '0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, W'(12), 1'b1, 1'b0);
      rst = 1'b1;
      tick();
      chk_out("rst_load", '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      drive(1'b1, '0, 1'b1, 1'b0);
      tick();
      chk_out("zero_load", '0, 1'b0, 1'b1, 1'b1);
      bus.load = 1'b0;
      tick();
      chk_out("zero_hold", '0, 1'b0, 1'b1, 1'b0);
      drive(1'b1, W'(20), 1'b1, 1'b0);
      tick();
      bus.load = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk_out("abort_pre", W'(15), 1'b1, 1'b0, 1'b0);
      bus.abort = 1'b1;
      tick();
      chk_out("abort", '0, 1'b0, 1'b0, 1'b0);
      bus.abort = 1'b0;
      tick();
      chk_out("abort_idle", '0, 1'b0, 1'b0, 1'b0);
      drive(1'b1, W'(10), 1'b1, 1'b0);
      tick();
      bus.load = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      chk_out("rst_pre", W'(7), 1'b1, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      chk_out("rst_mid", '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      tick();
      chk_out("rst_after", '0, 1'b0, 1'b0, 1'b0);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
      drive(1'b1, W'(3), 1'b1, 1'b0);
      tick();
      chk_out("ar_load", W'(3), 1'b1, 1'b0, 1'b0);
      bus.load = 1'b0;
      e = W'(3);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         t = (e == W'(1));
         e = t ? W'(3) : e - W'(1);
         pulses += int'(t);
         tick();
         chk_out("ar_seq", e, 1'b1, 1'b0, t);
      end
      chk("ar_pulses", 32'(pulses), 32'd4);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
